spi_flash_cmd_engine: RTL and testbench
=======================================

Name: spi_flash_cmd_engine

Overview:
- Byte-level SPI master for the SPI flash controller.
- Shifts out an opcode and an optional 24-bit address, then clocks in cmd_rlen bytes, emitting each byte as a one-cycle cmd_rvalid/cmd_rdata beat.
- Ends every transaction with a one-cycle cmd_done pulse.
- Sits between the controller FSM (issues cmd_start) and the read-data collector, which packs cmd_rdata beats into a 32-bit AXI word.

Parameters:
- CLK_DIV, 2, sck half-period in spi_clk cycles; legal range 1..255.
- CS_SETUP, 2, spi_clk cycles cs_n is held low before the first sck rise; minimum 1.
- CS_HOLD, 2, spi_clk cycles after the last sck fall before cs_n rises; minimum 1.
- RLEN_W, 3, width of cmd_rlen.

Ports:
- spi_clk  in  1  system clock.
- spi_reset  in  1  asynchronous, active-high reset.
- cmd_start  in  1  start request; sampled only in IDLE.
- cmd_code  in  8  opcode.
- cmd_addr_en  in  1  1 = send cmd_addr after opcode.
- cmd_addr  in  24  flash byte address, sent MSB first.
- cmd_rlen  in  RLEN_W  number of bytes to read (0 allowed).
- cmd_busy  out  1  high from the cycle after accept until cmd_done.
- cmd_rvalid  out  1  one-cycle pulse per received byte.
- cmd_rdata  out  8  received byte; valid while cmd_rvalid is high.
- cmd_done  out  1  one-cycle pulse at transaction end.
- spi_sck  out  1  serial clock, mode 0 (idle low).
- spi_cs_n  out  1  chip select, active low.
- spi_mosi  out  1  serial data out.
- spi_miso  in  1  serial data in.

Behaviour:
- Reset: the following apply immediately and asynchronously:
  - spi_cs_n=1, spi_sck=0, spi_mosi=0.
  - cmd_busy=0, cmd_rvalid=0, cmd_done=0, cmd_rdata=0.
  - State forced to IDLE.
  - A reset mid-transfer aborts the transfer; no cmd_done pulse is emitted.
- State machine transitions:
  - IDLE to CS_SETUP: cmd_start=1. Latch code/addr_en/addr/rlen. Next cycle: cs_n=0, busy=1, mosi=cmd_code[7].
  - CS_SETUP to TX: after CS_SETUP cycles.
  - TX shifts 8 bits (opcode), plus 24 bits if addr_en.
  - TX to RX: rlen≠0.
  - TX to CS_HOLD: rlen=0.
  - RX to CS_HOLD: after rlen bytes.
  - CS_HOLD to DONE: after CS_HOLD cycles with sck low, cs_n driven 1.
  - DONE lasts one cycle: cmd_done=1, busy=0 on the following cycle, then IDLE.
- Bit timing:
  - Each bit is CLK_DIV cycles with sck=0, followed by CLK_DIV cycles with sck=1.
  - mosi changes only at the start of a low phase; the first bit is valid at cs_n fall.
  - miso is sampled on the spi_clk edge that drives sck 0 to 1.
- Byte alignment:
  - Bytes are shifted MSB first.
  - The 8th sample of an RX byte produces cmd_rvalid=1 with the assembled byte on the next spi_clk edge.
  - mosi=0 during RX.
- Ordering and spacing:
  - cmd_done never coincides with cmd_rvalid; the last cmd_rvalid precedes cmd_done by at least CS_HOLD+1 cycles.
  - Minimum spacing between cmd_rvalid pulses is 16*CLK_DIV cycles.
- Edge counts:
  - Rising sck edges per transaction = 8 + 24*addr_en + 8*rlen.
  - No sck edges occur outside CS_SETUP..CS_HOLD.
- Input handling:
  - cmd_start while busy or in DONE is ignored; no queueing.
  - cmd_* inputs may change freely after accept.
- Counters: an 8-bit divider counter, a 5-bit bit counter (0..31 for TX) and an RLEN_W-bit byte counter. None wraps; each reloads on a state change.

Decomposition:
- Package spi_flash_pkg contains:
  - Opcode constants: READ=0x03, FAST_READ=0x0B, RDSR=0x05, WREN=0x06, PP=0x02, SE=0x20.
  - Engine state encoding.
  - The shared controller state encoding: IDLE 0, SEND_CODE_ADDR 1, READ_WAIT 2, WRITE_DATA 3, FINISH_DONE 4.
- One sub-module, spi_flash_sck_gen:
  - Holds the divider counter.
  - Outputs sck plus single-cycle rise_en/fall_en strobes.
  - Enabled only in CS_SETUP..CS_HOLD.

Test Plan:
- Plain read: CLK_DIV=2, code=0x03, addr_en=1, addr=0x123456, rlen=4; model returns 0xDE,0xAD,0xBE,0xEF.
  - mosi carries 0x03,0x12,0x34,0x56.
  - 64 sck rises.
  - cmd_rvalid pulses 4 times with 0xDE,0xAD,0xBE,0xEF, spaced 32 cycles apart.
  - One cmd_done occurs ≥3 cycles after the last rvalid.
  - The downstream collector word reads 0xEFBEADDE.
- Status read: code=0x05, addr_en=0, rlen=1, miso byte 0x01.
  - 16 sck rises.
  - One rvalid with 0x01, then cmd_done.
- Write enable: code=0x06, addr_en=0, rlen=0.
  - 8 sck rises, mosi=0x06.
  - No rvalid.
  - cs_n low for exactly CS_SETUP+16*CLK_DIV+CS_HOLD cycles, then cmd_done.
- Start during busy: pulse cmd_start with code=0x20 mid-transaction.
  - Ignored; the original transaction completes unchanged with exactly one cmd_done.
- Reset mid-read: assert spi_reset during byte 2 of an rlen=4 read.
  - cs_n=1, sck=0, busy=0 immediately with no cmd_done.
  - A following READ (0x03, addr=0x000000, rlen=1) completes normally.
- CLK_DIV=1 (fastest): run the rlen=4 read.
  - sck toggles every cycle.
  - rvalid spacing is 16 cycles; data is correct.

Source files
------------

// File: rtl/spi_flash_pkg.sv
// spi_flash_pkg: definitions shared by the SPI flash controller slice.
//   - flash opcode constants
//   - command engine state encoding
//   - controller state encoding (shared with the controller FSM)
//   - divider counter width and a TX bit-count helper
package spi_flash_pkg;

  // Flash opcodes
  localparam logic [7:0] OP_READ      = 8'h03;
  localparam logic [7:0] OP_FAST_READ = 8'h0B;
  localparam logic [7:0] OP_RDSR      = 8'h05;
  localparam logic [7:0] OP_WREN      = 8'h06;
  localparam logic [7:0] OP_PP        = 8'h02;
  localparam logic [7:0] OP_SE        = 8'h20;

  // Width of the sck divider and chip-select timing counters
  localparam int DIV_CNT_W = 8;

  // Command engine states
  typedef enum logic [2:0] {
    ENG_IDLE     = 3'd0,
    ENG_CS_SETUP = 3'd1,
    ENG_TX       = 3'd2,
    ENG_RX       = 3'd3,
    ENG_CS_HOLD  = 3'd4,
    ENG_DONE     = 3'd5
  } eng_state_e;

  // Controller states (owned by the controller FSM, shared encoding)
  typedef enum logic [2:0] {
    CTRL_IDLE           = 3'd0,
    CTRL_SEND_CODE_ADDR = 3'd1,
    CTRL_READ_WAIT      = 3'd2,
    CTRL_WRITE_DATA     = 3'd3,
    CTRL_FINISH_DONE    = 3'd4
  } ctrl_state_e;

  // Index of the last TX bit: opcode only, or opcode plus 24-bit address
  function automatic logic [4:0] tx_last_bit(input logic addr_en);
    return addr_en ? 5'd31 : 5'd7;
  endfunction

endpackage

// File: rtl/spi_flash_sck_gen.sv
// spi_flash_sck_gen: mode-0 serial clock generator.
// While en is high, sck spends CLK_DIV cycles low then CLK_DIV cycles high
// per bit, starting with a low phase. While en is low, sck is held low and
// the divider is cleared so the next enable starts a fresh low phase.
// Ports:
//   spi_clk   in   system clock
//   spi_reset in   asynchronous active-high reset
//   en        in   run the divider (engine in TX or RX)
//   sck       out  registered serial clock
//   rise_en   out  this cycle's clock edge drives sck 0->1
//   fall_en   out  this cycle's clock edge drives sck 1->0
module spi_flash_sck_gen
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic spi_clk,
  input  logic spi_reset,
  input  logic en,
  output logic sck,
  output logic rise_en,
  output logic fall_en
);

  localparam logic [DIV_CNT_W-1:0] DIV_LAST = DIV_CNT_W'(CLK_DIV - 1);
  localparam logic [DIV_CNT_W-1:0] DIV_ONE  = DIV_CNT_W'(1);

  logic [DIV_CNT_W-1:0] div_cnt_r;
  logic                 sck_r;
  logic                 phase_end_s;

  assign phase_end_s = en && (div_cnt_r == DIV_LAST);
  assign rise_en     = phase_end_s && !sck_r;
  assign fall_en     = phase_end_s && sck_r;
  assign sck         = sck_r;

  // Divider counter and sck phase register
  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset) begin
      div_cnt_r <= '0;
      sck_r     <= 1'b0;
    end else if (!en) begin
      div_cnt_r <= '0;
      sck_r     <= 1'b0;
    end else if (phase_end_s) begin
      div_cnt_r <= '0;
      sck_r     <= !sck_r;
    end else begin
      div_cnt_r <= div_cnt_r + DIV_ONE;
    end
  end

endmodule

// File: rtl/spi_flash_cmd_engine.sv
// spi_flash_cmd_engine: byte-level SPI master for the flash controller.
// Sends an opcode (plus optional 24-bit address) MSB first, then reads
// cmd_rlen bytes, emitting one cmd_rvalid/cmd_rdata beat per byte, and
// ends every transaction with a one-cycle cmd_done pulse.
// Ports:
//   spi_clk, spi_reset           clock, asynchronous active-high reset
//   cmd_start/code/addr_en/addr/rlen   command request (sampled in IDLE)
//   cmd_busy, cmd_rvalid, cmd_rdata, cmd_done   command status / read data
//   spi_sck, spi_cs_n, spi_mosi, spi_miso       SPI mode-0 bus
module spi_flash_cmd_engine
  import spi_flash_pkg::*;
#(
  parameter int CLK_DIV  = 2,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int RLEN_W   = 3
) (
  input  logic              spi_clk,
  input  logic              spi_reset,
  input  logic              cmd_start,
  input  logic [7:0]        cmd_code,
  input  logic              cmd_addr_en,
  input  logic [23:0]       cmd_addr,
  input  logic [RLEN_W-1:0] cmd_rlen,
  output logic              cmd_busy,
  output logic              cmd_rvalid,
  output logic [7:0]        cmd_rdata,
  output logic              cmd_done,
  output logic              spi_sck,
  output logic              spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso
);

  localparam logic [DIV_CNT_W-1:0] SETUP_LAST = DIV_CNT_W'(CS_SETUP - 1);
  localparam logic [DIV_CNT_W-1:0] HOLD_LAST  = DIV_CNT_W'(CS_HOLD - 1);
  localparam logic [DIV_CNT_W-1:0] CS_ONE     = DIV_CNT_W'(1);
  localparam logic [RLEN_W-1:0]    RLEN_ONE   = RLEN_W'(1);

  eng_state_e           state_r, state_next_s;
  logic [30:0]          tx_sr_r;      // remaining TX bits; bit 30 is the next one out
  logic                 addr_en_r;
  logic [RLEN_W-1:0]    rlen_r;
  logic [4:0]           bit_cnt_r;
  logic [RLEN_W-1:0]    byte_cnt_r;
  logic [DIV_CNT_W-1:0] cs_cnt_r;
  logic [6:0]           rx_sr_r;      // first seven bits of the byte in flight
  logic                 cs_n_r, busy_r, done_r, mosi_r, rvalid_r;
  logic [7:0]           rdata_r;

  logic sck_en_s, rise_en_s, fall_en_s;
  logic accept_s, tx_bit_end_s, tx_end_s, rx_bit_end_s, rx_byte_s, rx_end_s;
  logic cs_active_next_s;

  assign sck_en_s     = (state_r == ENG_TX) || (state_r == ENG_RX);
  assign accept_s     = (state_r == ENG_IDLE) && cmd_start;
  assign tx_bit_end_s = (state_r == ENG_TX) && fall_en_s;
  assign tx_end_s     = tx_bit_end_s && (bit_cnt_r == tx_last_bit(addr_en_r));
  assign rx_bit_end_s = (state_r == ENG_RX) && fall_en_s;
  // 8th sample of a byte happens on the rise while bit_cnt is 7
  assign rx_byte_s    = (state_r == ENG_RX) && rise_en_s && (bit_cnt_r == 5'd7);
  // RX ends on the fall after the last byte so sck is low in CS_HOLD
  assign rx_end_s     = rx_bit_end_s && (bit_cnt_r == 5'd7) &&
                        (byte_cnt_r == (rlen_r - RLEN_ONE));

  spi_flash_sck_gen #(
    .CLK_DIV (CLK_DIV)
  ) u_sck_gen (
    .spi_clk   (spi_clk),
    .spi_reset (spi_reset),
    .en        (sck_en_s),
    .sck       (spi_sck),
    .rise_en   (rise_en_s),
    .fall_en   (fall_en_s)
  );

  // Engine state register
  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset) begin
      state_r <= ENG_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic and chip-select decode for the next cycle
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ENG_IDLE: begin
        if (cmd_start) state_next_s = ENG_CS_SETUP;
        else           state_next_s = ENG_IDLE;
      end
      ENG_CS_SETUP: begin
        if (cs_cnt_r == SETUP_LAST) state_next_s = ENG_TX;
        else                        state_next_s = ENG_CS_SETUP;
      end
      ENG_TX: begin
        if (tx_end_s) state_next_s = (rlen_r != '0) ? ENG_RX : ENG_CS_HOLD;
        else          state_next_s = ENG_TX;
      end
      ENG_RX: begin
        if (rx_end_s) state_next_s = ENG_CS_HOLD;
        else          state_next_s = ENG_RX;
      end
      ENG_CS_HOLD: begin
        if (cs_cnt_r == HOLD_LAST) state_next_s = ENG_DONE;
        else                       state_next_s = ENG_CS_HOLD;
      end
      ENG_DONE: state_next_s = ENG_IDLE;
      default:  state_next_s = ENG_IDLE;
    endcase
  end

  assign cs_active_next_s = (state_next_s == ENG_CS_SETUP) || (state_next_s == ENG_TX) ||
                            (state_next_s == ENG_RX) || (state_next_s == ENG_CS_HOLD);

  // Bit, byte and chip-select counters; all reload on any state change
  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset) begin
      bit_cnt_r  <= 5'd0;
      byte_cnt_r <= '0;
      cs_cnt_r   <= '0;
    end else if (state_next_s != state_r) begin
      bit_cnt_r  <= 5'd0;
      byte_cnt_r <= '0;
      cs_cnt_r   <= '0;
    end else begin
      case (state_r)
        ENG_CS_SETUP, ENG_CS_HOLD: cs_cnt_r <= cs_cnt_r + CS_ONE;
        ENG_TX: begin
          if (tx_bit_end_s) bit_cnt_r <= bit_cnt_r + 5'd1;
        end
        ENG_RX: begin
          if (rx_bit_end_s && (bit_cnt_r == 5'd7)) begin
            bit_cnt_r  <= 5'd0;
            byte_cnt_r <= byte_cnt_r + RLEN_ONE;
          end else if (rx_bit_end_s) begin
            bit_cnt_r <= bit_cnt_r + 5'd1;
          end
        end
        default: begin
          bit_cnt_r <= bit_cnt_r;
        end
      endcase
    end
  end

  // Command latch and MOSI shifter; MOSI only moves on accept or a TX sck fall
  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset) begin
      tx_sr_r   <= 31'd0;
      addr_en_r <= 1'b0;
      rlen_r    <= '0;
      mosi_r    <= 1'b0;
    end else if (accept_s) begin
      tx_sr_r   <= {cmd_code[6:0], (cmd_addr_en ? cmd_addr : 24'h000000)};
      addr_en_r <= cmd_addr_en;
      rlen_r    <= cmd_rlen;
      mosi_r    <= cmd_code[7];
    end else if (tx_bit_end_s) begin
      tx_sr_r   <= {tx_sr_r[29:0], 1'b0};
      mosi_r    <= tx_end_s ? 1'b0 : tx_sr_r[30];
    end
  end

  // MISO shifter and read-data beat
  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset) begin
      rx_sr_r  <= 7'd0;
      rvalid_r <= 1'b0;
      rdata_r  <= 8'h00;
    end else begin
      rvalid_r <= rx_byte_s;
      if ((state_r == ENG_RX) && rise_en_s) rx_sr_r <= {rx_sr_r[5:0], spi_miso};
      if (rx_byte_s) rdata_r <= {rx_sr_r, spi_miso};
    end
  end

  // Registered status outputs, decoded from the state being entered
  always_ff @(posedge spi_clk or posedge spi_reset) begin
    if (spi_reset) begin
      cs_n_r <= 1'b1;
      busy_r <= 1'b0;
      done_r <= 1'b0;
    end else begin
      cs_n_r <= !cs_active_next_s;
      busy_r <= (state_next_s != ENG_IDLE);
      done_r <= (state_next_s == ENG_DONE);
    end
  end

  assign spi_cs_n   = cs_n_r;
  assign spi_mosi   = mosi_r;
  assign cmd_busy   = busy_r;
  assign cmd_done   = done_r;
  assign cmd_rvalid = rvalid_r;
  assign cmd_rdata  = rdata_r;

endmodule

// File: tb/tb_spi_flash_cmd_engine.sv
// Directed testbench for spi_flash_cmd_engine. Two instances: CLK_DIV=2
// (sel=0) and CLK_DIV=1 (sel=1), observed through a shared output mux.
module tb_spi_flash_cmd_engine;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cmd_start   = 1'b0;
  logic        sel         = 1'b0;
  logic [7:0]  cmd_code    = 8'h00;
  logic        cmd_addr_en = 1'b0;
  logic [23:0] cmd_addr    = 24'h0;
  logic [2:0]  cmd_rlen    = 3'd0;
  logic        miso;
  logic        s_start, f_start;

  logic       s_busy, s_rvalid, s_done, s_sck, s_cs_n, s_mosi;
  logic [7:0] s_rdata;
  logic       f_busy, f_rvalid, f_done, f_sck, f_cs_n, f_mosi;
  logic [7:0] f_rdata;
  logic       m_busy, m_rvalid, m_done, m_sck, m_cs_n, m_mosi;
  logic [7:0] m_rdata;

  assign s_start  = cmd_start & ~sel;
  assign f_start  = cmd_start & sel;
  assign m_busy   = sel ? f_busy   : s_busy;
  assign m_rvalid = sel ? f_rvalid : s_rvalid;
  assign m_done   = sel ? f_done   : s_done;
  assign m_sck    = sel ? f_sck    : s_sck;
  assign m_cs_n   = sel ? f_cs_n   : s_cs_n;
  assign m_mosi   = sel ? f_mosi   : s_mosi;
  assign m_rdata  = sel ? f_rdata  : s_rdata;

  spi_flash_cmd_engine #(.CLK_DIV(2), .CS_SETUP(2), .CS_HOLD(2), .RLEN_W(3)) dut (
    .spi_clk(clk), .spi_reset(rst), .cmd_start(s_start), .cmd_code(cmd_code),
    .cmd_addr_en(cmd_addr_en), .cmd_addr(cmd_addr), .cmd_rlen(cmd_rlen),
    .cmd_busy(s_busy), .cmd_rvalid(s_rvalid), .cmd_rdata(s_rdata), .cmd_done(s_done),
    .spi_sck(s_sck), .spi_cs_n(s_cs_n), .spi_mosi(s_mosi), .spi_miso(miso));

  spi_flash_cmd_engine #(.CLK_DIV(1), .CS_SETUP(2), .CS_HOLD(2), .RLEN_W(3)) dut_fast (
    .spi_clk(clk), .spi_reset(rst), .cmd_start(f_start), .cmd_code(cmd_code),
    .cmd_addr_en(cmd_addr_en), .cmd_addr(cmd_addr), .cmd_rlen(cmd_rlen),
    .cmd_busy(f_busy), .cmd_rvalid(f_rvalid), .cmd_rdata(f_rdata), .cmd_done(f_done),
    .spi_sck(f_sck), .spi_cs_n(f_cs_n), .spi_mosi(f_mosi), .spi_miso(miso));

  int errors = 0;
  int checks = 0;

  // Bus monitor state
  int          cyc = 0, rises = 0, toggles = 0, cs_low = 0;
  int          rv_cnt = 0, done_cnt = 0, done_cyc = 0, overlap = 0, bad_sck = 0;
  int          rv_cyc [8];
  logic [7:0]  rv_data [8];
  logic [63:0] mosi_sr = 64'h0;
  logic [31:0] coll = 32'h0;
  logic        prev_sck = 1'b0;

  // Flash model: bit i of the transaction (i = sck rises so far) comes from the stream MSB down
  logic [63:0] miso_stream = 64'h0;
  logic [5:0]  midx;
  assign midx = 6'(63 - rises);
  assign miso = (rises < 64) ? miso_stream[midx] : 1'b0;

  // Monitor sampled on the falling clock edge
  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (m_sck && !prev_sck) begin
      rises   <= rises + 1;
      mosi_sr <= {mosi_sr[62:0], m_mosi};
    end
    if (m_sck != prev_sck) toggles <= toggles + 1;
    prev_sck <= m_sck;
    if (!m_cs_n) cs_low <= cs_low + 1;
    if (m_sck && m_cs_n) bad_sck <= bad_sck + 1;
    if (m_rvalid) begin
      if (rv_cnt < 8) begin
        rv_cyc[rv_cnt[2:0]]  <= cyc;
        rv_data[rv_cnt[2:0]] <= m_rdata;
      end
      rv_cnt <= rv_cnt + 1;
      coll   <= {m_rdata, coll[31:8]};
    end
    if (m_done) begin
      done_cnt <= done_cnt + 1;
      done_cyc <= cyc;
      if (m_rvalid) overlap <= overlap + 1;
    end
  end

  task automatic clear_mon();
    @(posedge clk); #1;
    rises = 0; toggles = 0; cs_low = 0; rv_cnt = 0; done_cnt = 0;
    overlap = 0; bad_sck = 0; mosi_sr = 64'h0; coll = 32'h0;
  endtask

  task automatic set_resp(input int tx_bits, input logic [31:0] data);
    miso_stream = {32'h0, data} << (32 - tx_bits);
  endtask

  task automatic start_cmd(input logic [7:0] code, input logic ae,
                           input logic [23:0] addr, input logic [2:0] rlen);
    @(negedge clk);
    cmd_code = code; cmd_addr_en = ae; cmd_addr = addr; cmd_rlen = rlen;
    cmd_start = 1'b1;
    @(posedge clk); #1;
    cmd_start = 1'b0;
  endtask

  task automatic wait_done(input int max_cyc, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (m_done) begin ok = 1'b1; break; end
    end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if ({s_cs_n, s_sck, s_mosi, s_busy, s_rvalid, s_done, s_rdata} !== {1'b1, 5'b0, 8'h00}) begin
      errors++; $display("FAIL reset_slow: got %b want 1_00000_00000000",
                         {s_cs_n, s_sck, s_mosi, s_busy, s_rvalid, s_done, s_rdata});
    end
    checks++;
    if ({f_cs_n, f_sck, f_mosi, f_busy, f_rvalid, f_done, f_rdata} !== {1'b1, 5'b0, 8'h00}) begin
      errors++; $display("FAIL reset_fast: got %b want 1_00000_00000000",
                         {f_cs_n, f_sck, f_mosi, f_busy, f_rvalid, f_done, f_rdata});
    end
    @(negedge clk); rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  // rlen=4 read of 0xDEADBEEF at 0x123456; spacing is the expected rvalid gap
  task automatic test_read4(input string tag, input int spacing, input int exp_cs_low);
    bit ok;
    logic [31:0] w = 32'hDEADBEEF;
    clear_mon();
    set_resp(32, w);
    start_cmd(8'h03, 1'b1, 24'h123456, 3'd4);
    @(negedge clk);
    checks++;
    if ({m_busy, m_cs_n, m_mosi} !== 3'b100) begin
      errors++; $display("FAIL %s_accept: busy/cs_n/mosi=%b want 100", tag, {m_busy, m_cs_n, m_mosi});
    end
    wait_done(3000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL %s_timeout: no cmd_done", tag); end
    checks++; if (rises !== 64) begin errors++; $display("FAIL %s_rises: got %0d want 64", tag, rises); end
    checks++;
    if (mosi_sr !== 64'h03123456_00000000) begin
      errors++; $display("FAIL %s_mosi: got %h want 0312345600000000", tag, mosi_sr);
    end
    checks++; if (rv_cnt !== 4) begin errors++; $display("FAIL %s_rvcnt: got %0d want 4", tag, rv_cnt); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (rv_data[i] !== w[31-8*i -: 8]) begin
        errors++; $display("FAIL %s_rdata%0d: got %h want %h", tag, i, rv_data[i], w[31-8*i -: 8]);
      end
    end
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (rv_cyc[i+1] - rv_cyc[i] !== spacing) begin
        errors++; $display("FAIL %s_spacing%0d: got %0d want %0d", tag, i, rv_cyc[i+1] - rv_cyc[i], spacing);
      end
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL %s_done: got %0d want 1", tag, done_cnt); end
    checks++;
    if (done_cyc - rv_cyc[3] < 3) begin
      errors++; $display("FAIL %s_done_gap: got %0d want >=3", tag, done_cyc - rv_cyc[3]);
    end
    checks++; if (coll !== 32'hEFBEADDE) begin errors++; $display("FAIL %s_word: got %h want efbeadde", tag, coll); end
    checks++; if (cs_low !== exp_cs_low) begin errors++; $display("FAIL %s_cslow: got %0d want %0d", tag, cs_low, exp_cs_low); end
    checks++;
    if ({overlap, bad_sck, 31'd0, m_busy} !== 65'd0) begin
      errors++; $display("FAIL %s_order: overlap=%0d bad_sck=%0d busy=%b want 0 0 0", tag, overlap, bad_sck, m_busy);
    end
  endtask

  task automatic test_plain_read();
    sel = 1'b0;
    test_read4("read", 32, 260);
  endtask

  task automatic test_status_read();
    bit ok;
    clear_mon();
    set_resp(8, 32'h01000000);
    start_cmd(8'h05, 1'b0, 24'h0, 3'd1);
    wait_done(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rdsr_timeout: no cmd_done"); end
    checks++; if (rises !== 16) begin errors++; $display("FAIL rdsr_rises: got %0d want 16", rises); end
    checks++; if (mosi_sr[15:0] !== 16'h0500) begin errors++; $display("FAIL rdsr_mosi: got %h want 0500", mosi_sr[15:0]); end
    checks++; if (rv_cnt !== 1) begin errors++; $display("FAIL rdsr_rvcnt: got %0d want 1", rv_cnt); end
    checks++; if (rv_data[0] !== 8'h01) begin errors++; $display("FAIL rdsr_rdata: got %h want 01", rv_data[0]); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rdsr_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_wren();
    bit ok;
    clear_mon();
    set_resp(8, 32'h0);
    start_cmd(8'h06, 1'b0, 24'h0, 3'd0);
    wait_done(1000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL wren_timeout: no cmd_done"); end
    checks++; if (rises !== 8) begin errors++; $display("FAIL wren_rises: got %0d want 8", rises); end
    checks++; if (mosi_sr[7:0] !== 8'h06) begin errors++; $display("FAIL wren_mosi: got %h want 06", mosi_sr[7:0]); end
    checks++; if (rv_cnt !== 0) begin errors++; $display("FAIL wren_rvcnt: got %0d want 0", rv_cnt); end
    checks++; if (cs_low !== 36) begin errors++; $display("FAIL wren_cslow: got %0d want 36", cs_low); end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL wren_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_start_busy();
    bit ok;
    clear_mon();
    set_resp(32, 32'h5AC30000);
    start_cmd(8'h03, 1'b1, 24'hABCDEF, 3'd2);
    repeat (40) @(negedge clk);
    cmd_code = 8'h20; cmd_addr_en = 1'b0; cmd_rlen = 3'd0; cmd_start = 1'b1;
    @(negedge clk); cmd_start = 1'b0;
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL busy_timeout: no cmd_done"); end
    checks++; if (rises !== 48) begin errors++; $display("FAIL busy_rises: got %0d want 48", rises); end
    checks++;
    if (mosi_sr[47:0] !== 48'h03ABCDEF0000) begin
      errors++; $display("FAIL busy_mosi: got %h want 03abcdef0000", mosi_sr[47:0]);
    end
    checks++; if (rv_cnt !== 2) begin errors++; $display("FAIL busy_rvcnt: got %0d want 2", rv_cnt); end
    checks++;
    if ({rv_data[0], rv_data[1]} !== 16'h5AC3) begin
      errors++; $display("FAIL busy_rdata: got %h%h want 5ac3", rv_data[0], rv_data[1]);
    end
    repeat (30) @(negedge clk);
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL busy_done: got %0d want 1", done_cnt); end
    checks++; if (cs_low !== 196) begin errors++; $display("FAIL busy_cslow: got %0d want 196", cs_low); end
  endtask

  task automatic test_reset_mid_read();
    bit ok;
    clear_mon();
    set_resp(32, 32'hDEADBEEF);
    start_cmd(8'h03, 1'b1, 24'h123456, 3'd4);
    ok = 1'b0;
    for (int i = 0; i < 1000; i++) begin
      @(negedge clk);
      if (m_rvalid) begin ok = 1'b1; break; end
    end
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_timeout: no first rvalid"); end
    repeat (10) @(negedge clk);
    rst = 1'b1;
    #1;
    checks++;
    if ({m_cs_n, m_sck, m_busy, m_done, m_rvalid} !== 5'b10000) begin
      errors++; $display("FAIL rstmid_abort: cs_n/sck/busy/done/rvalid=%b want 10000",
                         {m_cs_n, m_sck, m_busy, m_done, m_rvalid});
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++; if (done_cnt !== 0) begin errors++; $display("FAIL rstmid_nodone: got %0d want 0", done_cnt); end
    clear_mon();
    set_resp(32, 32'hA5000000);
    start_cmd(8'h03, 1'b1, 24'h000000, 3'd1);
    wait_done(2000, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rstmid_rd_timeout: no cmd_done"); end
    checks++; if (rises !== 40) begin errors++; $display("FAIL rstmid_rises: got %0d want 40", rises); end
    checks++;
    if (mosi_sr[39:0] !== 40'h0300000000) begin
      errors++; $display("FAIL rstmid_mosi: got %h want 0300000000", mosi_sr[39:0]);
    end
    checks++;
    if ({rv_cnt[3:0], rv_data[0]} !== {4'd1, 8'hA5}) begin
      errors++; $display("FAIL rstmid_rdata: cnt=%0d data=%h want 1 a5", rv_cnt, rv_data[0]);
    end
    checks++; if (done_cnt !== 1) begin errors++; $display("FAIL rstmid_done: got %0d want 1", done_cnt); end
  endtask

  task automatic test_fast();
    sel = 1'b1;
    repeat (2) @(negedge clk);
    test_read4("fast", 16, 132);
    checks++; if (toggles !== 128) begin errors++; $display("FAIL fast_toggles: got %0d want 128", toggles); end
    sel = 1'b0;
  endtask

  initial begin
    test_reset();
    test_plain_read();
    test_status_read();
    test_wren();
    test_start_busy();
    test_reset_mid_read();
    test_fast();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
